div_seq: RTL and testbench

//  Multi-cycle radix-2 restoring divide sequencer serving the EX stage for DIV/DIVU.
//  - EX raises i_start with operands and holds it while o_ready is low.
//  - EX drives its pause_ctrl stall request from (i_start & ~o_ready), so the pipeline freezes until the result is ready.
//  - The 64-bit result goes to EX for the HI/LO write: HI = remainder, LO = quotient.

---
 rtl/div_seq.sv | 119 +++++++++++
 tb/tb_div_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Returns {remainder, quotient} N_WIDTH+1 cycles after accept, or one cycle after accept for a zero divisor.
module div_seq #(
  parameter int N_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_signed,
  input  logic [N_WIDTH-1:0]   i_dividend,
  input  logic [N_WIDTH-1:0]   i_divisor,
  input  logic                 i_annul,
  output logic [2*N_WIDTH-1:0] o_result,
  output logic                 o_ready,
  output logic                 o_busy
);

  localparam int CW = $clog2(N_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [2*N_WIDTH-1:0] r_result;
  logic                 r_ready;
  logic [N_WIDTH-1:0]   r_rem;
  logic [N_WIDTH-1:0]   r_quo;
  logic [N_WIDTH-1:0]   r_dvs;
  logic                 r_neg_q;
  logic                 r_neg_r;

  logic [N_WIDTH-1:0]   w_dvd_abs;
  logic [N_WIDTH-1:0]   w_dvs_abs;
  logic [N_WIDTH:0]     w_rem_sh;
  logic [N_WIDTH-1:0]   w_diff;
  logic                 w_ge;
  logic [N_WIDTH-1:0]   w_quo_fix;
  logic [N_WIDTH-1:0]   w_rem_fix;
  logic                 w_accept;
  logic                 w_iter;

  assign w_accept  = (r_state == S_IDLE) & i_start & ~i_annul;
  assign w_iter    = (r_state == S_ON) & (r_cnt != CW'(N_WIDTH));
  assign w_dvd_abs = (i_signed & i_dividend[N_WIDTH-1]) ? -i_dividend : i_dividend;
  assign w_dvs_abs = (i_signed & i_divisor[N_WIDTH-1])  ? -i_divisor  : i_divisor;

  // The shifted partial remainder needs one extra bit; a successful subtract always fits back in N bits.
  assign w_rem_sh  = {r_rem, r_quo[N_WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_diff    = w_rem_sh[N_WIDTH-1:0] - r_dvs;

  // Overflow (most negative / -1) needs no special case: |dividend| wraps to itself and both signs agree.
  assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

  assign o_result  = r_result;
  assign o_ready   = r_ready;
  assign o_busy    = (r_state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else if (i_annul && r_state != S_IDLE) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_state <= (i_divisor == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          r_result <= '0;
          r_ready  <= 1'b1;
          r_state  <= S_END;
        end
        S_ON: begin
          if (w_iter) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_result <= {w_rem_fix, w_quo_fix};
            r_ready  <= 1'b1;
            r_state  <= S_END;
          end
        end
        S_END: begin
          if (!i_start) begin
            r_result <= '0;
            r_ready  <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath: no reset needed, every field is loaded on accept before it is used.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_rem   <= '0;
      r_quo   <= w_dvd_abs;
      r_dvs   <= w_dvs_abs;
      r_neg_q <= i_signed & (i_dividend[N_WIDTH-1] ^ i_divisor[N_WIDTH-1]);
      r_neg_r <= i_signed & i_dividend[N_WIDTH-1];
    end else if (w_iter) begin
      r_quo <= {r_quo[N_WIDTH-2:0], w_ge};
      r_rem <= w_ge ? w_diff : w_rem_sh[N_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboarded bench for div_seq: directed corner cases plus random DIV/DIVU against a plain-arithmetic model.
module tb_div_seq;

  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           sgn;
  logic [N-1:0]   dividend;
  logic [N-1:0]   divisor;
  logic           annul;
  logic [2*N-1:0] result;
  logic           ready;
  logic           busy;

  int checks = 0;
  int errors = 0;
  logic [2*N-1:0] exp_q[$];
  logic           prev_ready = 1'b0;

  div_seq #(.N_WIDTH(N)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_signed(sgn),
    .i_dividend(dividend), .i_divisor(divisor), .i_annul(annul),
    .o_result(result), .o_ready(ready), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*N-1:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic s);
    longint sa, sb, q, r;
    logic [63:0] uq, ur;
    if (b == '0) return '0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[N-1:0], q[N-1:0]};
    end
    uq = {32'd0, a} / {32'd0, b};
    ur = {32'd0, a} % {32'd0, b};
    return {ur[N-1:0], uq[N-1:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every rising o_ready must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready && !prev_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: got result %h with nothing outstanding", result);
      end else begin
        automatic logic [2*N-1:0] e = exp_q.pop_front();
        if (result !== e) begin
          errors++;
          $display("FAIL result: got %h expected %h", result, e);
        end
      end
    end
    prev_ready = ready;
  end

  task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    int n;
    int lat;
    logic [2*N-1:0] e;
    e = ref_div(a, b, s);
    lat = (b == '0) ? 2 : N + 2;
    @(negedge clk);
    start = 1'b1; sgn = s; dividend = a; divisor = b;
    exp_q.push_back(e);
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_accept", 64'(busy), 64'd1);
      // Operands are ignored once accepted.
      dividend = $urandom; divisor = $urandom; sgn = $urandom_range(0, 1);
      if (ready) break;
    end
    check("latency", 64'(n), 64'(lat));
    if (!ready) begin
      start = 1'b0;
      return;
    end
    @(negedge clk);
    check("end_hold_ready", 64'(ready), 64'd1);
    check("end_hold_result", result, e);
    start = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(ready), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_result", result, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; dividend = '0; divisor = '0; annul = 1'b0;
    #1;
    check("reset_result", result, 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_div(32'd100, 32'd7, 1'b0);
    do_div(-32'sd7, 32'd2, 1'b1);
    do_div(32'd7, -32'sd2, 1'b1);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0);
    do_div(32'd12345, 32'd0, 1'b1);
    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Annul mid-divide: nothing is pushed, so any o_ready rise is flagged by the monitor.
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; dividend = 32'd100; divisor = 32'd7;
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    check("annul_busy", 64'(busy), 64'd0);
    check("annul_ready", 64'(ready), 64'd0);
    annul = 1'b0; start = 1'b0;
    @(negedge clk);
    do_div(32'd100, 32'd7, 1'b0);

    // Asynchronous reset mid-divide.
    @(negedge clk);
    start = 1'b1; sgn = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_ready", 64'(ready), 64'd0);
    check("midreset_result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_div(32'd100, 32'd7, 1'b0);

    for (int i = 0; i < 30; i++) begin
      automatic logic [N-1:0] a = $urandom;
      automatic logic [N-1:0] b;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(1, 15);
        1: b = (i % 5 == 0) ? '0 : -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      do_div(a, b, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
